// File: rtl/cdda_play_sequencer.sv
// CD-DA play sequencer: arms, unmutes, pauses and drains the I2S repad path, counting frames for sector/EFFK timing.
// Optional LRCLK-loss watchdog enabled by defining CDDA_WATCHDOG_EN.
module cdda_play_sequencer #(
  parameter int ARM_FRAMES    = 4,
  parameter int DRAIN_FRAMES  = 2,
  parameter int SECTOR_FRAMES = 588,
  parameter int EFFK_FRAMES   = 6
`ifdef CDDA_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic       MCLK,
  input  logic       RESET_n,
  input  logic       LRCLK_IN,
  input  logic       cmd_play,
  input  logic       cmd_pause,
  input  logic       cmd_stop,
  input  logic       emph_in,
  output logic       path_en,
  output logic       MUTE,
  output logic       AEMP,
  output logic       playing,
  output logic [9:0] frame_cnt,
  output logic       sector_tick,
  output logic       effk_tick,
  output logic       fault
);

  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int DW = $clog2(DRAIN_FRAMES + 1);
  localparam int EW = $clog2(EFFK_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, ARM, PLAY, PAUSE, DRAIN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   arm_cnt, arm_nx;
  logic [DW-1:0]   drain_cnt, drain_nx;
  logic [EW-1:0]   effk_cnt, effk_nx;
  logic [9:0]      frame_nx;
  logic            aemp_nx, sector_nx, effk_tick_nx;
  logic            lr_s1, lr_s2, lr_s3, fe;
  logic            do_stop, do_pause, do_play;

  // Coincident commands resolve as stop > pause > play
  assign do_stop  = cmd_stop;
  assign do_pause = cmd_pause & ~cmd_stop;
  assign do_play  = cmd_play & ~cmd_pause & ~cmd_stop;

  always_ff @(posedge MCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      lr_s1 <= 1'b0;
      lr_s2 <= 1'b0;
      lr_s3 <= 1'b0;
      fe    <= 1'b0;
    end else begin
      lr_s1 <= LRCLK_IN;
      lr_s2 <= lr_s1;
      lr_s3 <= lr_s2;
      fe    <= lr_s2 & ~lr_s3;
    end
  end

`ifdef CDDA_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt, wdog_nx;
  logic          fault_nx;
`endif

  always_comb begin
    state_nx     = state;
    arm_nx       = arm_cnt;
    drain_nx     = drain_cnt;
    effk_nx      = effk_cnt;
    frame_nx     = frame_cnt;
    aemp_nx      = AEMP;
    sector_nx    = 1'b0;
    effk_tick_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (do_play) begin
          state_nx = ARM;
          arm_nx   = '0;
          frame_nx = '0;
          effk_nx  = '0;
        end
      end
      ARM: begin
        if (do_stop) begin
          state_nx = IDLE;
        end else if (fe) begin
          if (arm_cnt == AW'(ARM_FRAMES - 1)) state_nx = PLAY;
          arm_nx = arm_cnt + 1'b1;
        end
      end
      PLAY: begin
        if (do_stop) begin
          state_nx = DRAIN;
          drain_nx = '0;
        end else if (do_pause) begin
          state_nx = PAUSE;
        end else if (fe) begin
          if (frame_cnt == 10'(SECTOR_FRAMES - 1)) begin
            frame_nx  = '0;
            sector_nx = 1'b1;
            aemp_nx   = emph_in;
          end else begin
            frame_nx = frame_cnt + 10'd1;
          end
          if (effk_cnt == EW'(EFFK_FRAMES - 1)) begin
            effk_nx      = '0;
            effk_tick_nx = 1'b1;
          end else begin
            effk_nx = effk_cnt + 1'b1;
          end
        end
      end
      PAUSE: begin
        if (do_stop) begin
          state_nx = DRAIN;
          drain_nx = '0;
        end else if (do_play) begin
          state_nx = PLAY;
        end
      end
      DRAIN: begin
        if (fe) begin
          if (drain_cnt == DW'(DRAIN_FRAMES - 1)) state_nx = IDLE;
          else drain_nx = drain_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef CDDA_WATCHDOG_EN
    fault_nx = fault;
    wdog_nx  = '0;
    if (state == IDLE && do_play) fault_nx = 1'b0;
    // Frame loss overrides any command in the same cycle
    if (state == ARM || state == PLAY || state == PAUSE) begin
      if (wdog_cnt == WW'(WDOG_CYCLES)) begin
        state_nx = IDLE;
        fault_nx = 1'b1;
      end else if (!fe) begin
        wdog_nx = wdog_cnt + 1'b1;
      end
    end
`endif
    if (state_nx == IDLE) aemp_nx = 1'b0;
  end

  // Outputs are registered from the next state so they move together with it
  always_ff @(posedge MCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      arm_cnt     <= '0;
      drain_cnt   <= '0;
      effk_cnt    <= '0;
      frame_cnt   <= '0;
      AEMP        <= 1'b0;
      sector_tick <= 1'b0;
      effk_tick   <= 1'b0;
      path_en     <= 1'b0;
      MUTE        <= 1'b1;
      playing     <= 1'b0;
    end else begin
      state       <= state_nx;
      arm_cnt     <= arm_nx;
      drain_cnt   <= drain_nx;
      effk_cnt    <= effk_nx;
      frame_cnt   <= frame_nx;
      AEMP        <= aemp_nx;
      sector_tick <= sector_nx;
      effk_tick   <= effk_tick_nx;
      path_en     <= (state_nx != IDLE);
      MUTE        <= (state_nx != PLAY);
      playing     <= (state_nx == PLAY);
    end
  end

`ifdef CDDA_WATCHDOG_EN
  always_ff @(posedge MCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wdog_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      wdog_cnt <= wdog_nx;
      fault    <= fault_nx;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cdda_play_sequencer.sv
// Self-checking bench for cdda_play_sequencer: vector table, frame-level reference model with random commands,
// and hand sequences for sector wrap, pause/resume, watchdog and asynchronous reset.
module tb_cdda_play_sequencer;

  localparam int FRAME_CYC = 16;
  localparam int ARMF      = 4;
  localparam int DRAINF    = 2;
  localparam int SECTOR    = 588;
  localparam int EFFK      = 6;

  logic       MCLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       LRCLK_IN = 1'b0;
  logic       cmd_play = 1'b0;
  logic       cmd_pause = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       emph_in = 1'b0;
  logic       path_en, MUTE, AEMP, playing, sector_tick, effk_tick, fault;
  logic [9:0] frame_cnt;

  cdda_play_sequencer dut (
    .MCLK(MCLK), .RESET_n(RESET_n), .LRCLK_IN(LRCLK_IN),
    .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop), .emph_in(emph_in),
    .path_en(path_en), .MUTE(MUTE), .AEMP(AEMP), .playing(playing), .frame_cnt(frame_cnt),
    .sector_tick(sector_tick), .effk_tick(effk_tick), .fault(fault)
  );

  always #5 MCLK = ~MCLK;

  int   checks = 0;
  int   errors = 0;
  int   ph = FRAME_CYC - 1;
  bit   lr_run = 1'b1;
  event mid_ev;

  // LRCLK source: rises at phase 0; mid_ev marks the quiet middle of each frame
  initial begin
    forever begin
      @(negedge MCLK);
      if (lr_run) begin
        ph = (ph + 1) % FRAME_CYC;
        LRCLK_IN = (ph < FRAME_CYC / 2);
        if (ph == FRAME_CYC / 2) -> mid_ev;
      end
    end
  end

  int dut_sec = 0;
  int dut_effk = 0;
  bit fc_over = 1'b0;
  always @(negedge MCLK) begin
    if (sector_tick === 1'b1) dut_sec++;
    if (effk_tick === 1'b1) dut_effk++;
    if (frame_cnt > 10'(SECTOR - 1)) fc_over = 1'b1;
  end

  // Frame-level reference model: 0 idle, 1 arm, 2 play, 3 pause, 4 drain
  int m_st, m_arm, m_fc, m_ec, m_dr;
  int m_sec = 0;
  int m_effk = 0;
  bit m_aemp, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_arm = 0; m_fc = 0; m_ec = 0; m_dr = 0; m_aemp = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_cmd(input bit p, input bit pa, input bit s);
    if (s) begin
      if (m_st == 1) m_st = 0;
      else if (m_st == 2 || m_st == 3) begin m_st = 4; m_dr = 0; end
    end else if (pa) begin
      if (m_st == 2) m_st = 3;
    end else if (p) begin
      if (m_st == 0) begin
        m_st = 1; m_arm = 0; m_fc = 0; m_ec = 0; m_fault = 1'b0;
      end else if (m_st == 3) m_st = 2;
    end
  endtask

  task automatic model_frame();
    case (m_st)
      1: begin m_arm++; if (m_arm == ARMF) m_st = 2; end
      2: begin
        m_fc = (m_fc + 1) % SECTOR;
        if (m_fc == 0) begin m_sec++; m_aemp = emph_in; end
        m_ec = (m_ec + 1) % EFFK;
        if (m_ec == 0) m_effk++;
      end
      4: begin m_dr++; if (m_dr == DRAINF) begin m_st = 0; m_aemp = 1'b0; end end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input bit p, input bit pa, input bit s, input int nfr);
    cmd_play = p; cmd_pause = pa; cmd_stop = s;
    @(negedge MCLK);
    cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
    model_cmd(p, pa, s);
    repeat (nfr) begin
      @(mid_ev);
      model_frame();
    end
  endtask

  task automatic checkOutput(input string tag);
    chk($sformatf("%s.path_en", tag), path_en, m_st != 0);
    chk($sformatf("%s.mute", tag), MUTE, m_st != 2);
    chk($sformatf("%s.playing", tag), playing, m_st == 2);
    chk($sformatf("%s.frame_cnt", tag), frame_cnt, m_fc);
    chk($sformatf("%s.aemp", tag), AEMP, m_aemp);
    chk($sformatf("%s.fault", tag), fault, m_fault);
    chk($sformatf("%s.sector_ticks", tag), dut_sec, m_sec);
    chk($sformatf("%s.effk_ticks", tag), dut_effk, m_effk);
    chk($sformatf("%s.fc_range", tag), fc_over, 0);
  endtask

  typedef struct {
    bit p, pa, s;
    int nfr;
    bit e_path, e_mute, e_play;
    int e_fc;
  } vec_t;

  vec_t vecs[12];
  int   sec_base, effk_base, r;
  bit   rp, rpa, rs;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1, 5};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 5};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 5};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 6};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 6};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 6};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 6};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0};

    model_reset();
    repeat (3) @(negedge MCLK);
    checkOutput("reset");
    RESET_n = 1'b1;
    @(mid_ev);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].p, vecs[i].pa, vecs[i].s, vecs[i].nfr);
      chk($sformatf("vec%0d.path_en", i), path_en, vecs[i].e_path);
      chk($sformatf("vec%0d.mute", i), MUTE, vecs[i].e_mute);
      chk($sformatf("vec%0d.playing", i), playing, vecs[i].e_play);
      chk($sformatf("vec%0d.frame_cnt", i), frame_cnt, vecs[i].e_fc);
    end
    checkOutput("table_end");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      rp  = (r <= 3) || r == 6 || r == 7;
      rpa = (r == 4) || r == 7;
      rs  = (r == 5) || r == 6;
      emph_in = 1'($urandom_range(0, 1));
      applyStimulus(rp, rpa, rs, $urandom_range(0, 12));
      checkOutput($sformatf("rnd%0d", i));
    end

    // Full sector with a pause at frame 100 and emphasis raised mid-sector
    emph_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    effk_base = m_effk;
    sec_base  = m_sec;
    applyStimulus(1'b0, 1'b0, 1'b0, ARMF);
    checkOutput("armed");
    applyStimulus(1'b0, 1'b0, 1'b0, 100);
    chk("fc_100", frame_cnt, 100);
    applyStimulus(1'b0, 1'b1, 1'b0, 10);
    chk("pause_mute", MUTE, 1);
    chk("pause_hold", frame_cnt, 100);
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    chk("resume_fc", frame_cnt, 100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    chk("resume_step", frame_cnt, 101);
    applyStimulus(1'b0, 1'b0, 1'b0, 199);
    emph_in = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 287);
    chk("fc_587", frame_cnt, 587);
    chk("aemp_pre_wrap", AEMP, 0);
    chk("no_sector_yet", dut_sec, sec_base);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    chk("fc_wrap", frame_cnt, 0);
    chk("aemp_post_wrap", AEMP, 1);
    chk("one_sector", dut_sec, sec_base + 1);
    chk("effk_98", dut_effk, effk_base + 98);
    checkOutput("sector");

    // LRCLK stall while playing
    lr_run = 1'b0;
    repeat (1100) @(negedge MCLK);
`ifdef CDDA_WATCHDOG_EN
    m_st = 0; m_aemp = 1'b0; m_fault = 1'b1;
    checkOutput("wdog_trip");
    chk("wdog_fault", fault, 1);
    lr_run = 1'b1;
    @(mid_ev);
    model_frame();
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("wdog_clear");
`else
    checkOutput("no_wdog");
    chk("no_wdog_playing", playing, 1);
    lr_run = 1'b1;
    @(mid_ev);
    model_frame();
    checkOutput("no_wdog_resume");
`endif

    // Asynchronous reset in the middle of a sector
    emph_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, ARMF);
    applyStimulus(1'b0, 1'b0, 1'b0, 300);
    chk("fc_300", frame_cnt, 300);
    @(posedge MCLK);
    #2 RESET_n = 1'b0;
    #1;
    chk("arst.path_en", path_en, 0);
    chk("arst.mute", MUTE, 1);
    chk("arst.playing", playing, 0);
    chk("arst.frame_cnt", frame_cnt, 0);
    chk("arst.aemp", AEMP, 0);
    chk("arst.ticks", {sector_tick, effk_tick}, 0);
    chk("arst.fault", fault, 0);
    model_reset();
    @(negedge MCLK);
    RESET_n = 1'b1;
    @(mid_ev);
    model_frame();
    checkOutput("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
